time_base_monitor: RTL and testbench

//  Consumer end of the time_base pulse interface. Receives tic_enable/accum_enable,

---
 rtl/time_base_monitor.sv | 152 +++++++++++++++
 tb/tb_time_base_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_base_monitor.sv
// Consumer of the time_base tic/accum pulses: sticky event flags, saturating overrun counts,
// per-channel period checkers and a maskable irq. Optional macro TB_MONITOR_TIMESTAMP_EN adds tic_stamp.
module time_base_monitor #(
    parameter int DIV_W = 24,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tic_enable,
    input  logic             accum_enable,
    input  logic [DIV_W-1:0] tic_divide,
    input  logic [DIV_W-1:0] accum_divide,
    input  logic [1:0]       irq_mask,
    input  logic             status_rd,
    output logic [31:0]      status_dout,
    output logic             status_valid,
    output logic             irq
`ifdef TB_MONITOR_TIMESTAMP_EN
    ,
    output logic [31:0]      tic_stamp
`endif
);

    localparam int CNT_W = DIV_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OVR_W-1:0] OVR_ONE = OVR_W'(1);

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } chk_state_e;

    // Channel index 1 = tic, 0 = accum, matching the irq_mask and status bit order.
    logic [1:0]       pulse;
    logic [DIV_W-1:0] div_in [2];

    assign pulse     = {tic_enable, accum_enable};
    assign div_in[1] = tic_divide;
    assign div_in[0] = accum_divide;

    logic [1:0]       flag_q, flag_d;
    logic [1:0]       perr_q, perr_d;
    logic [OVR_W-1:0] ovr_q  [2];
    logic [OVR_W-1:0] ovr_d  [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [DIV_W-1:0] div_q  [2];
    chk_state_e       chk_q  [2];
    chk_state_e       chk_d  [2];
    logic [31:0]      status_dout_q, status_dout_d;
    logic             status_valid_q;
    logic             irq_q, irq_d;
    logic [11:0]      mid_field;

`ifdef TB_MONITOR_TIMESTAMP_EN
    logic [31:0] stamp_cnt_q, stamp_cnt_d;
    logic [31:0] tic_stamp_q, tic_stamp_d;

    assign stamp_cnt_d = stamp_cnt_q + 32'd1;
    assign tic_stamp_d = tic_enable ? stamp_cnt_q : tic_stamp_q;
    assign mid_field   = tic_stamp_q[11:0];
    assign tic_stamp   = tic_stamp_q;
`else
    assign mid_field   = 12'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        flag_d = '0;
        perr_d = '0;
        for (int ch = 0; ch < 2; ch++) begin
            logic div_chg;
            logic period_bad;
            div_chg    = (div_q[ch] != div_in[ch]);
            period_bad = pulse[ch] && (chk_q[ch] == ARMED) && !div_chg &&
                         (cnt_q[ch] != ({1'b0, div_in[ch]} + CNT_ONE));

            // A new pulse always wins over the clear from a read in the same cycle.
            flag_d[ch] = pulse[ch] | (flag_q[ch] & ~status_rd);
            perr_d[ch] = period_bad | (perr_q[ch] & ~status_rd);

            if (status_rd)
                ovr_d[ch] = '0;
            else if (pulse[ch] && flag_q[ch] && !(&ovr_q[ch]))
                ovr_d[ch] = ovr_q[ch] + OVR_ONE;
            else
                ovr_d[ch] = ovr_q[ch];

            if (pulse[ch])
                cnt_d[ch] = CNT_ONE;
            else if (&cnt_q[ch])
                cnt_d[ch] = cnt_q[ch];
            else
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;

            // A divider change throws away the running period; a coincident pulse starts a fresh one.
            if (div_chg)
                chk_d[ch] = pulse[ch] ? ARMED : DISARMED;
            else if (pulse[ch])
                chk_d[ch] = ARMED;
            else
                chk_d[ch] = chk_q[ch];
        end

        status_dout_d = status_rd ?
            {8'(ovr_q[1]), 8'(ovr_q[0]), mid_field, perr_q[1], perr_q[0], flag_q[1], flag_q[0]} :
            status_dout_q;
        irq_d = |(flag_d & irq_mask);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            flag_q         <= '0;
            perr_q         <= '0;
            status_dout_q  <= '0;
            status_valid_q <= 1'b0;
            irq_q          <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                ovr_q[ch] <= '0;
                cnt_q[ch] <= '0;
                div_q[ch] <= '0;
                chk_q[ch] <= DISARMED;
            end
`ifdef TB_MONITOR_TIMESTAMP_EN
            stamp_cnt_q <= '0;
            tic_stamp_q <= '0;
`endif
        end else begin
            flag_q         <= flag_d;
            perr_q         <= perr_d;
            status_dout_q  <= status_dout_d;
            status_valid_q <= status_rd;
            irq_q          <= irq_d;
            for (int ch = 0; ch < 2; ch++) begin
                ovr_q[ch] <= ovr_d[ch];
                cnt_q[ch] <= cnt_d[ch];
                div_q[ch] <= div_in[ch];
                chk_q[ch] <= chk_d[ch];
            end
`ifdef TB_MONITOR_TIMESTAMP_EN
            stamp_cnt_q <= stamp_cnt_d;
            tic_stamp_q <= tic_stamp_d;
`endif
        end
    end

    assign status_dout  = status_dout_q;
    assign status_valid = status_valid_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_time_base_monitor.sv
// Directed bench for time_base_monitor: a per-cycle vector table plus hand-written sequences
// for overrun saturation, period checking, set-wins reads and mid-run reset.
module tb_time_base_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        tic_enable, accum_enable, status_rd;
    logic [23:0] tic_divide, accum_divide;
    logic [1:0]  irq_mask;
    logic [31:0] status_dout;
    logic        status_valid, irq;
`ifdef TB_MONITOR_TIMESTAMP_EN
    logic [31:0] tic_stamp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_base_monitor #(.DIV_W(24), .OVR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .tic_enable   (tic_enable),
        .accum_enable (accum_enable),
        .tic_divide   (tic_divide),
        .accum_divide (accum_divide),
        .irq_mask     (irq_mask),
        .status_rd    (status_rd),
        .status_dout  (status_dout),
        .status_valid (status_valid),
        .irq          (irq)
`ifdef TB_MONITOR_TIMESTAMP_EN
        ,
        .tic_stamp    (tic_stamp)
`endif
    );

    typedef struct {
        logic        tic;
        logic        acc;
        logic        rd;
        logic [1:0]  mask;
        logic        exp_irq;
        logic        exp_valid;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, let the edge consume them, then sample 1 ns later.
    task automatic step(input logic t, input logic a, input logic r);
        tic_enable   = t;
        accum_enable = a;
        status_rd    = r;
        @(posedge clk);
        #1;
        tic_enable   = 1'b0;
        accum_enable = 1'b0;
        status_rd    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  status_dout, 32'h0);
        check({tag, "_valid"}, {31'b0, status_valid}, 32'h0);
        check({tag, "_irq"},   {31'b0, irq}, 32'h0);
`ifdef TB_MONITOR_TIMESTAMP_EN
        check({tag, "_stamp"}, tic_stamp, 32'h0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_all_zero(tag);
        rst = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] exp_dout);
        step(1'b0, 1'b0, 1'b1);
        check({name, "_dout"},  status_dout, exp_dout);
        check({name, "_valid"}, {31'b0, status_valid}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        tic_enable   = 1'b0;
        accum_enable = 1'b0;
        status_rd    = 1'b0;
        tic_divide   = 24'd2;
        accum_divide = 24'd2;
        irq_mask     = 2'b11;

        // Table: both periods expect 3 clk; each row is one cycle, expected values after its edge.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h0100_0003};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0100_0003};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0100_0003};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0007};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0100_000F};

        do_reset("reset0");
        for (int i = 0; i < 14; i++) begin
            irq_mask = vecs[i].mask;
            step(vecs[i].tic, vecs[i].acc, vecs[i].rd);
            check($sformatf("vec%0d_irq", i),   {31'b0, irq},          {31'b0, vecs[i].exp_irq});
            check($sformatf("vec%0d_valid", i), {31'b0, status_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_dout", i),  status_dout,           vecs[i].exp_dout);
        end

        // Four accum pulses on the programmed period: three overruns, no period error.
        accum_divide = 24'd4;
        irq_mask     = 2'b01;
        do_reset("reset1");
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) begin
            idle(4);
            step(1'b0, 1'b1, 1'b0);
        end
        check("t1_irq", {31'b0, irq}, 32'h1);
        read_check("t1_read", 32'h0003_0001);
        check("t1_irq_after", {31'b0, irq}, 32'h0);

        // Gaps 5 then 4: the short period sets acc_perr; a second read sees nothing new.
        do_reset("reset2");
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        read_check("t2_read", 32'h0002_0005);
        read_check("t2_reread", 32'h0000_0000);

        // Pulse coinciding with a read: captured value excludes it, flag survives, no overrun.
        tic_divide = 24'd9;
        irq_mask   = 2'b10;
        do_reset("reset3");
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        check("t3_irq_set", {31'b0, irq}, 32'h1);
        idle(9);
        step(1'b1, 1'b0, 1'b1);
        check("t3_dout", status_dout, 32'h0000_0002);
        check("t3_valid", {31'b0, status_valid}, 32'h1);
        check("t3_irq_kept", {31'b0, irq}, 32'h1);
        read_check("t3_reread", 32'h0000_0002);
        check("t3_irq_clear", {31'b0, irq}, 32'h0);

        // 300 back-to-back tic pulses at period 1: overrun saturates at 255.
        tic_divide = 24'd0;
        do_reset("reset4");
        idle(1);
        repeat (300) step(1'b1, 1'b0, 1'b0);
        read_check("t4_sat", 32'hFF00_0002);

        // Divider changes 9 -> 19 between pulses: the gap-10 pulse only re-arms.
        tic_divide = 24'd9;
        do_reset("reset5");
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        tic_divide = 24'd19;
        idle(7);
        step(1'b1, 1'b0, 1'b0);
        idle(19);
        step(1'b1, 1'b0, 1'b0);
        read_check("t5_rearm", 32'h0300_0002);

        // Reset mid-run with a read and pulses in the same cycle: everything returns to zero.
        irq_mask   = 2'b11;
        tic_divide = 24'd2;
        do_reset("reset6");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t6_irq_pre", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        check_all_zero("t6_midrst");
        rst = 1'b0;
        read_check("t6_after", 32'h0000_0000);

`ifdef TB_MONITOR_TIMESTAMP_EN
        // Timestamp: tic pulse on the 100th cycle after release latches 100.
        do_reset("reset7");
        idle(100);
        step(1'b1, 1'b0, 1'b0);
        check("t7_stamp", tic_stamp, 32'd100);
        read_check("t7_read", 32'h0000_0642);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        check_all_zero("t7_midrst");
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
